// File: rtl/stream_fifo_sync.sv
// stream_fifo_sync: synchronous valid/ready stream FIFO with a circular buffer.
// Parameters:
//   FALL_THROUGH - 1: when the FIFO is empty, data_i/valid_i pass straight to
//                  data_o/valid_o; 0: minimum one-cycle latency.
//   DEPTH        - number of storage entries (>= 1).
//   T            - payload type (any packed type).
// Optional macro STREAM_FIFO_ASSERT_EN compiles in simulation-only protocol
// checks. Without it the block behaves identically and has no checks.
module stream_fifo_sync #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         T            = logic,
    localparam int unsigned USAGE_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               testmode_i,
    output logic [USAGE_W-1:0] usage_o,
    input  T                   data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output T                   data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    // A single entry still needs a one-bit pointer that stays at zero.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [USAGE_W-1:0] count;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;
    logic wr_en;
    logic rd_en;

    // The test-mode input has no effect on this block.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == USAGE_W'(DEPTH));
    assign ready_o = !full;
    assign usage_o = count;

    assign push   = valid_i && ready_o;
    assign pop    = valid_o && ready_i;
    // An empty fall-through FIFO hands a same-cycle accepted beat straight
    // across, so storage and pointers are left alone.
    assign bypass = FALL_THROUGH && empty && push && ready_i;
    assign wr_en  = push && !bypass;
    assign rd_en  = pop && !bypass;

    // Output side: head of the buffer, or the input itself when empty in fall-through.
    always_comb begin
        valid_o = !empty;
        data_o  = mem[rd_ptr];
        if (empty) begin
            if (FALL_THROUGH) begin
                valid_o = valid_i;
                data_o  = data_i;
            end else begin
                data_o = '0;
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr_en && !rd_en) begin
                count <= count + USAGE_W'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - USAGE_W'(1);
            end
        end
    end

    // Storage array: cleared on reset, written at the write pointer on push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (!flush_i && wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

`ifdef STREAM_FIFO_ASSERT_EN
    if (DEPTH < 1) begin : g_depth_check
        $error("stream_fifo_sync: DEPTH must be at least 1");
    end

    // Protocol checks: no push into a full FIFO, no pop from an empty one.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push && full) begin
            $error("stream_fifo_sync: push while full");
        end
        if (!rst_i && pop && empty && !bypass) begin
            $error("stream_fifo_sync: pop while empty");
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo_sync.sv
// Bench for stream_fifo_sync: vector table on a depth-2 FIFO, hand-written
// corner sequences, and randomized traffic against a queue reference model.
module tb_stream_fifo_sync;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total_cnt  = 0;
    int passed_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            passed_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Depth 2, no fall-through, 32-bit payload
    logic        f2, v2, r2, vo2, ro2;
    logic [31:0] d2, do2;
    logic [1:0]  u2;
    stream_fifo_sync #(.FALL_THROUGH(1'b0), .DEPTH(2), .T(logic [31:0])) u_d2 (
        .clk_i(clk), .rst_i(rst), .flush_i(f2), .testmode_i(1'b0), .usage_o(u2),
        .data_i(d2), .valid_i(v2), .ready_o(ro2), .data_o(do2), .valid_o(vo2), .ready_i(r2)
    );

    // Depth 1, no fall-through
    logic       v1, r1, vo1, ro1;
    logic [7:0] d1, do1;
    logic [0:0] u1;
    stream_fifo_sync #(.FALL_THROUGH(1'b0), .DEPTH(1), .T(logic [7:0])) u_d1 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b0), .usage_o(u1),
        .data_i(d1), .valid_i(v1), .ready_o(ro1), .data_o(do1), .valid_o(vo1), .ready_i(r1)
    );

    // Depth 4: index 0 without fall-through, index 1 with fall-through
    logic       rv [2];
    logic       rr [2];
    logic       rf [2];
    logic [7:0] rd [2];
    logic       vo [2];
    logic       ro [2];
    logic [7:0] dout [2];
    logic [2:0] uo [2];
    stream_fifo_sync #(.FALL_THROUGH(1'b0), .DEPTH(4), .T(logic [7:0])) u_d4 (
        .clk_i(clk), .rst_i(rst), .flush_i(rf[0]), .testmode_i(1'b0), .usage_o(uo[0]),
        .data_i(rd[0]), .valid_i(rv[0]), .ready_o(ro[0]), .data_o(dout[0]), .valid_o(vo[0]),
        .ready_i(rr[0])
    );
    stream_fifo_sync #(.FALL_THROUGH(1'b1), .DEPTH(4), .T(logic [7:0])) u_d4_ft (
        .clk_i(clk), .rst_i(rst), .flush_i(rf[1]), .testmode_i(1'b0), .usage_o(uo[1]),
        .data_i(rd[1]), .valid_i(rv[1]), .ready_o(ro[1]), .data_o(dout[1]), .valid_o(vo[1]),
        .ready_i(rr[1])
    );

    typedef struct {
        logic        flush;
        logic        valid;
        logic [31:0] data;
        logic        ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [1:0]  exp_usage;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    task automatic idle_all();
        f2 = 0; v2 = 0; r2 = 0; d2 = '0;
        v1 = 0; r1 = 0; d1 = '0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; rr[i] = 0; rf[i] = 0; rd[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random traffic on one depth-4 instance, checked against a queue model.
    task automatic rand_run(input int s, input bit ft, input int ncyc);
        logic [7:0] q[$];
        int         beat = 0;
        bit         pv   = 0;
        logic [7:0] pd   = '0;
        logic       er, ev, psh, pp;
        logic [7:0] ed;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (!pv && $urandom_range(0, 99) < 60) begin
                pv = 1;
                pd = 8'(beat);
                beat++;
            end
            rv[s] = pv;
            rd[s] = pd;
            rr[s] = ($urandom_range(0, 99) < 55);
            rf[s] = (c >= 100) && ($urandom_range(0, 63) == 0);
            er = (q.size() < 4);
            ev = (q.size() > 0) || (ft && pv);
            ed = (q.size() > 0) ? q[0] : (ft ? pd : 8'h00);
            #1;
            chk($sformatf("rnd%0d.c%0d.ready", s, c), ro[s], er);
            chk($sformatf("rnd%0d.c%0d.valid", s, c), vo[s], ev);
            chk($sformatf("rnd%0d.c%0d.usage", s, c), uo[s], q.size());
            if (ev) chk($sformatf("rnd%0d.c%0d.data", s, c), dout[s], ed);
            psh = pv && er;
            pp  = ev && rr[s];
            if (rf[s]) begin
                q.delete();
            end else if (!(q.size() == 0 && ft && psh && rr[s])) begin
                if (pp) void'(q.pop_front());
                if (psh) q.push_back(pd);
            end
            if (psh) pv = 0;
        end
        @(negedge clk);
        rv[s] = 0; rr[s] = 0; rf[s] = 0;
    endtask

    initial begin
        int beat;
        rst = 1'b1;
        idle_all();

        //            flush valid data    ready  ev er eu ed
        tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA};
        tbl[3]  = '{1'b0, 1'b1, 32'hF, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA};
        tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd2, 32'hA};
        tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB};
        tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'hD, 1'b1, 1'b1, 1'b1, 2'd1, 32'hC};
        tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hD};
        tbl[10] = '{1'b1, 1'b1, 32'hE, 1'b0, 1'b1, 1'b1, 2'd1, 32'hD};
        tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};

        do_reset();

        // Depth-2 vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            f2 = tbl[i].flush; v2 = tbl[i].valid; d2 = tbl[i].data; r2 = tbl[i].ready;
            #1;
            chk($sformatf("tbl%0d.valid", i), vo2, tbl[i].exp_valid);
            chk($sformatf("tbl%0d.ready", i), ro2, tbl[i].exp_ready);
            chk($sformatf("tbl%0d.usage", i), u2, tbl[i].exp_usage);
            chk($sformatf("tbl%0d.data", i), do2, tbl[i].exp_data);
        end
        @(negedge clk);
        f2 = 0; v2 = 0; r2 = 0;

        // Depth-1: held valid with ready high accepts every other cycle
        beat = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v1 = 1; r1 = 1; d1 = 8'(beat);
            #1;
            chk($sformatf("d1.k%0d.valid", k), vo1, (k % 2) == 1);
            chk($sformatf("d1.k%0d.ready", k), ro1, (k % 2) == 0);
            if ((k % 2) == 1) chk($sformatf("d1.k%0d.data", k), do1, 8'(beat - 1));
            else beat++;
        end
        @(negedge clk);
        v1 = 0; r1 = 0;

        // Fall-through: empty FIFO bypasses in the same cycle
        @(negedge clk);
        rv[1] = 1; rd[1] = 8'h55; rr[1] = 1;
        #1;
        chk("ft.bypass.data", dout[1], 8'h55);
        chk("ft.bypass.valid", vo[1], 1'b1);
        chk("ft.bypass.usage", uo[1], 3'd0);
        @(negedge clk);
        rv[1] = 0; rr[1] = 0;
        #1;
        chk("ft.after.usage", uo[1], 3'd0);
        chk("ft.after.valid", vo[1], 1'b0);
        // Fall-through with consumer stalled stores the beat
        @(negedge clk);
        rv[1] = 1; rd[1] = 8'h66; rr[1] = 0;
        #1;
        chk("ft.stall.data", dout[1], 8'h66);
        @(negedge clk);
        rv[1] = 0; rd[1] = 8'h00;
        #1;
        chk("ft.stored.usage", uo[1], 3'd1);
        chk("ft.stored.data", dout[1], 8'h66);
        rr[1] = 1;
        @(negedge clk);
        rr[1] = 0;
        #1;
        chk("ft.drained.usage", uo[1], 3'd0);

        // Flush with three entries and a simultaneous push
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rv[0] = 1; rd[0] = 8'(k); rr[0] = 0;
        end
        @(negedge clk);
        rv[0] = 1; rd[0] = 8'h77; rf[0] = 1;
        #1;
        chk("flush.cycle.usage", uo[0], 3'd3);
        chk("flush.cycle.data", dout[0], 8'h01);
        @(negedge clk);
        rv[0] = 0; rf[0] = 0; rr[0] = 1;
        #1;
        chk("flush.next.usage", uo[0], 3'd0);
        chk("flush.next.valid", vo[0], 1'b0);
        chk("flush.next.data", dout[0], 8'h00);
        @(negedge clk);
        #1;
        chk("flush.lost.valid", vo[0], 1'b0);
        rr[0] = 0;

        // Reset while two entries are stored
        @(negedge clk);
        v2 = 1; d2 = 32'h11; r2 = 0;
        @(negedge clk);
        d2 = 32'h22;
        @(negedge clk);
        v2 = 0;
        #1;
        chk("rst.pre.usage", u2, 2'd2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst.valid", vo2, 1'b0);
        chk("rst.ready", ro2, 1'b1);
        chk("rst.usage", u2, 2'd0);
        chk("rst.data", do2, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        rand_run(0, 1'b0, 300);
        do_reset();
        rand_run(1, 1'b1, 300);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
